// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the shared UART transmit arbiter.
// master = requesters/bench, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();
  localparam int unsigned BPW = 25;
  localparam int unsigned IDW = 3;

  logic [BPW-1:0]    bit_period;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              uart_send;
  logic [7:0]        uart_data;

  modport master (
    output bit_period, req, req_data,
    input  ack, busy, grant_id, uart_send, uart_data
  );

  modport slave (
    input  bit_period, req, req_data,
    output ack, busy, grant_id, uart_send, uart_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one busy-less UART transmitter between NREQ byte
// requesters; each frame is timed locally from a bit-period cycle count.
module uart_tx_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned HOLD_BITS  = 2,
  parameter int unsigned FRAME_BITS = 11
) (
  input  logic              clk_xtal,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int unsigned BPW = 25;
  localparam int unsigned IDW = 3;
  localparam int unsigned BCW = 4;

  typedef enum logic [1:0] {IDLE, HOLD, FRAME, DONE} state_t;

  state_t          state;
  logic [BPW-1:0]  bp;
  logic [BPW-1:0]  cyc;
  logic [BCW-1:0]  bitc;
  logic [IDW-1:0]  last;
  logic [NREQ-1:0] gnt_oh;

  logic            any_c;
  logic [IDW-1:0]  sel_c;
  logic [NREQ-1:0] sel_oh_c;
  logic [7:0]      sel_data_c;
  logic [BPW-1:0]  bp_eff_c;

  // Rotating-priority pick: indices above last first, then wrap to 0..last.
  always_comb begin
    any_c      = 1'b0;
    sel_c      = last;
    sel_oh_c   = '0;
    sel_data_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!any_c && bus.req[i] && (IDW'(i) > last)) begin
        any_c       = 1'b1;
        sel_c       = IDW'(i);
        sel_oh_c[i] = 1'b1;
        sel_data_c  = bus.req_data[8*i +: 8];
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!any_c && bus.req[i] && (IDW'(i) <= last)) begin
        any_c       = 1'b1;
        sel_c       = IDW'(i);
        sel_oh_c[i] = 1'b1;
        sel_data_c  = bus.req_data[8*i +: 8];
      end
    end
  end

  assign bp_eff_c = (bus.bit_period == '0) ? BPW'(1) : bus.bit_period;

  always_ff @(posedge clk_xtal or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bp            <= BPW'(1);
      cyc           <= '0;
      bitc          <= '0;
      last          <= IDW'(NREQ - 1);
      gnt_oh        <= '0;
      bus.ack       <= '0;
      bus.busy      <= 1'b0;
      bus.grant_id  <= IDW'(NREQ - 1);
      bus.uart_send <= 1'b0;
      bus.uart_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_c) begin
            state         <= HOLD;
            bp            <= bp_eff_c;
            cyc           <= bp_eff_c - BPW'(1);
            bitc          <= BCW'(HOLD_BITS - 1);
            last          <= sel_c;
            gnt_oh        <= sel_oh_c;
            bus.grant_id  <= sel_c;
            bus.uart_data <= sel_data_c;
            bus.busy      <= 1'b1;
            bus.uart_send <= 1'b1;
          end
        end
        HOLD: begin
          if (cyc != '0) begin
            cyc <= cyc - BPW'(1);
          end else if (bitc != '0) begin
            cyc  <= bp - BPW'(1);
            bitc <= bitc - BCW'(1);
          end else begin
            state         <= FRAME;
            cyc           <= bp - BPW'(1);
            bitc          <= BCW'(FRAME_BITS - 1);
            bus.uart_send <= 1'b0;
          end
        end
        FRAME: begin
          if (cyc != '0) begin
            cyc <= cyc - BPW'(1);
          end else if (bitc != '0) begin
            cyc  <= bp - BPW'(1);
            bitc <= bitc - BCW'(1);
          end else begin
            state   <= DONE;
            bus.ack <= gnt_oh;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.ack  <= '0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NREQ byte requesters with round-robin arbitration.
- Drives the UART's send and DataOut inputs.
- The UART has no busy output, so this block times each frame itself from a bit-period count, in clk_xtal cycles.
- Sits between the CPU-side sources (core, debug monitor, DMA) and the UART.

Parameters:
- NREQ, 4: number of requesters (2..8).
- HOLD_BITS, 2: bit periods uart_send is held high, so the UART's baud-clock edge samples and latches it.
- FRAME_BITS, 11: bit periods uart_send is held low afterwards. Covers the 10-bit frame plus 1 bit of margin and lets the UART re-arm its latch.

Ports:
- clk_xtal  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- bit_period  in  25  clk_xtal cycles per UART bit; 0 is treated as 1; sampled at grant.
- req  in  NREQ  request per requester; level, held until ack.
- req_data  in  8*NREQ  byte for requester i on bits [8i+7:8i].
- ack  out  NREQ  one-cycle pulse to the granted requester when its frame time completes.
- busy  out  1  high from grant until the ack cycle inclusive.
- grant_id  out  3  index of the current/last granted requester.
- uart_send  out  1  to UART send.
- uart_data  out  8  to UART DataOut; stable from grant through the ack cycle.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, busy=0, grant_id=NREQ-1, uart_send=0, uart_data=0, state=IDLE, last=NREQ-1. Requester 0 therefore has first priority after reset.
- Reset asserted mid-frame: the FSM returns to IDLE immediately (async); uart_send drops at once; no ack is issued for the aborted byte.
- States are IDLE, HOLD, FRAME, DONE.
- IDLE:
  - On a clock edge with any req bit high, select the first set bit scanning last+1, last+2, ... modulo NREQ.
  - On that edge: capture req_data[sel] into uart_data; set grant_id=sel and last=sel; latch bit_period (0 becomes 1); set busy=1 and uart_send=1; go to HOLD.
- HOLD:
  - Lasts exactly HOLD_BITS*bp cycles with uart_send=1.
  - On the final edge: uart_send=0, go to FRAME.
- FRAME:
  - Lasts exactly FRAME_BITS*bp cycles with uart_send=0.
  - On the final edge: ack[grant_id]=1, go to DONE.
- DONE:
  - One cycle with ack high and busy still 1.
  - On the next edge: ack=0, busy=0, go to IDLE.
- Arbitration timing: the earliest next grant is on the edge ending the first IDLE cycle. Minimum spacing between grants is (HOLD_BITS+FRAME_BITS)*bp+2 cycles.
- Timing counters: a 25-bit cycle counter counts bp-1 down to 0; a 4-bit bit counter tracks bits within the phase. No multiplier.
- Requester contract:
  - req_data needs to be valid only on the grant edge.
  - A req drop after grant does not abort the frame.
  - A requester drops req on the edge ending its ack cycle; a req still high in IDLE is a new request.
- Inputs ignored outside IDLE: req changes and bit_period changes have no effect while a frame is in flight.
- Simultaneous requests are resolved only by the rotating pointer; every active requester is served within NREQ grants.
- Exactly one ack bit is ever high; ack never asserts without a preceding grant.

Test Plan:
1. Reset, bit_period=4, req=4'b0001, req_data[7:0]=8'hA5 → uart_data=A5 and uart_send=1 for exactly 8 cycles, then 0 for 44 cycles; ack=4'b0001 in the 53rd cycle after grant; busy is 1 for 53 cycles.
2. req=4'b1111 held high, each requester dropping req at its ack, data 8'h10..8'h13 → grant order 0,1,2,3; uart_data sequence 10,11,12,13; grant-to-grant spacing 54 cycles at bit_period=4.
3. After requester 2 is served, req=4'b0101 → requester 0 is granted next (pointer wrap), then requester 2.
4. bit_period=0 with one request → behaves as bit_period=1: uart_send high 2 cycles, low 11 cycles, ack in cycle 14.
5. Reset asserted at cycle 20 of FRAME → uart_send=0, busy=0, ack=0 immediately; after release with req=4'b0010 → requester 1 is granted first, since last was reset to 3.
6. During HOLD, change req_data and bit_period to 8 → uart_data and frame length unchanged; the new bit_period applies only at the next grant.
